// File: rtl/mux_2x1_arbiter.sv
// Round-robin owner of a shared 2:1 output channel. Each tenure is capped at
// MAX_BURST transfers whenever the other requester is waiting.
module mux_2x1_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             out_ready,
    output logic             grant_a,
    output logic             grant_b,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             ack_a,
    output logic             ack_b
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          ptr_reg, ptr_next;   // last side served: 0 = A, 1 = B
    logic          sel_reg, sel_next;
    logic          xfer;
    logic          burst_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            ptr_reg   <= 1'b1;
            sel_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
        end
    end

    // The transfer that would complete the burst; only possible while the owner still requests.
    assign burst_done = xfer && (count_reg == LAST);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (req_a && (!req_b || ptr_reg))
                    state_next = GNT_A;
                else if (req_b)
                    state_next = GNT_B;
            end
            GNT_A: begin
                if (!req_a)
                    state_next = IDLE;
                else if (burst_done && req_b)
                    state_next = GNT_B;
            end
            GNT_B: begin
                if (!req_b)
                    state_next = IDLE;
                else if (burst_done && req_a)
                    state_next = GNT_A;
            end
            default: state_next = IDLE;
        endcase

        if (state_next != state_reg)
            count_next = '0;
        else if (burst_done)
            count_next = '0;
        else if (xfer)
            count_next = count_reg + 1'b1;

        // sel and the pointer only move on entry to a grant; IDLE keeps the old select.
        if (state_next == GNT_A && state_reg != GNT_A) begin
            ptr_next = 1'b0;
            sel_next = 1'b0;
        end else if (state_next == GNT_B && state_reg != GNT_B) begin
            ptr_next = 1'b1;
            sel_next = 1'b1;
        end
    end

    always_comb begin
        grant_a   = (state_reg == GNT_A);
        grant_b   = (state_reg == GNT_B);
        sel       = sel_reg;
        out_valid = (grant_a && req_a) || (grant_b && req_b);
        xfer      = out_valid && out_ready;
        ack_a     = xfer && grant_a;
        ack_b     = xfer && grant_b;
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
            assign out_data[gi] = sel_reg ? data_b[gi] : data_a[gi];
        end
    endgenerate

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed checks of the round-robin channel arbiter followed by a random
// invariant sweep; expected values are hand-derived per cycle.
module tb_mux_2x1_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_a, req_b, out_ready;
    logic [WIDTH-1:0] data_a, data_b;
    logic             grant_a, grant_b, sel, out_valid, ack_a, ack_b;
    logic [WIDTH-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;
    bit quiet    = 1'b0;
    int run_a    = 0;
    int run_b    = 0;

    always #5 clk = ~clk;

    mux_2x1_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .out_ready (out_ready),
        .grant_a   (grant_a),
        .grant_b   (grant_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ack_a     (ack_a),
        .ack_b     (ack_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else if (!quiet) begin
            $display("  %-14s ok (%0h)", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
        data_a = 8'h3C; data_b = 8'hA5;

        // 1: reset values, then alternating 4-word bursts under contention
        tick(); tick();
        check("rst_grant_a", grant_a, 0);
        check("rst_grant_b", grant_b, 0);
        check("rst_sel", sel, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ack_a", ack_a, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_data", out_data, 8'h3C);
        reset = 1'b0;
        tick();
        check("t1_grant_a", grant_a, 1);
        check("t1_sel_a", sel, 0);
        for (int i = 0; i < MAX_BURST; i++) begin
            check("t1_ack_a", ack_a, 1);
            check("t1_no_ack_b", ack_b, 0);
            check("t1_data_a", out_data, 8'h3C);
            tick();
        end
        check("t1_grant_b", grant_b, 1);
        check("t1_grant_a_off", grant_a, 0);
        check("t1_sel_b", sel, 1);
        for (int i = 0; i < MAX_BURST; i++) begin
            check("t1_ack_b", ack_b, 1);
            check("t1_data_b", out_data, 8'hA5);
            tick();
        end
        check("t1_back_a", grant_a, 1);

        // 2: lone requester keeps the grant across burst wraps
        req_a = 1'b0; req_b = 1'b1;
        do_reset();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t2_grant_b", grant_b, 1);
            check("t2_data", out_data, 8'hA5);
            check("t2_ack_b", ack_b, 1);
            tick();
        end
        req_b = 1'b0;
        settle();
        check("t2_drop_valid", out_valid, 0);
        check("t2_drop_ack", ack_b, 0);
        tick();
        check("t2_idle_gnt", grant_b, 0);
        check("t2_idle_sel", sel, 1);

        // 3: stalled downstream holds the grant, then the burst completes
        req_a = 1'b1; req_b = 1'b1; out_ready = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 20; i++) begin
            check("t3_hold_a", grant_a, 1);
            check("t3_valid", out_valid, 1);
            check("t3_no_ack", ack_a, 0);
            check("t3_no_gnt_b", grant_b, 0);
            tick();
        end
        out_ready = 1'b1;
        settle();
        for (int i = 0; i < MAX_BURST; i++) begin
            check("t3_ack_a", ack_a, 1);
            tick();
        end
        check("t3_switch_b", grant_b, 1);

        // 4: early release, dead cycle, then pointer favours B
        req_a = 1'b1; req_b = 1'b0;
        do_reset();
        tick();
        check("t4_ack1", ack_a, 1);
        tick();
        check("t4_ack2", ack_a, 1);
        tick();
        req_a = 1'b0;
        settle();
        check("t4_rel_valid", out_valid, 0);
        check("t4_rel_ack", ack_a, 0);
        check("t4_rel_gnt", grant_a, 1);
        tick();
        check("t4_idle_a", grant_a, 0);
        check("t4_idle_b", grant_b, 0);
        req_a = 1'b1;
        settle();
        check("t4_dead_cycle", grant_a, 0);
        tick();
        check("t4_regrant_a", grant_a, 1);
        check("t4_regrant_ack", ack_a, 1);
        req_a = 1'b0;
        tick();
        req_a = 1'b1; req_b = 1'b1;
        tick();
        check("t4_ptr_b", grant_b, 1);
        check("t4_ptr_not_a", grant_a, 0);

        // 5: reset in the middle of a B burst
        do_reset();
        tick();
        for (int i = 0; i < MAX_BURST; i++) tick();
        check("t5_in_b", grant_b, 1);
        tick(); tick();
        check("t5_still_b", grant_b, 1);
        reset = 1'b1;
        tick();
        check("t5_rst_a", grant_a, 0);
        check("t5_rst_b", grant_b, 0);
        check("t5_rst_sel", sel, 0);
        check("t5_rst_valid", out_valid, 0);
        reset = 1'b0;
        tick();
        check("t5_after_a", grant_a, 1);
        check("t5_after_sel", sel, 0);

        // 6: random traffic, invariant checks only
        quiet = 1'b1;
        run_a = 0;
        run_b = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 9) < 2) req_a = ~req_a;
            if ($urandom_range(0, 9) < 2) req_b = ~req_b;
            out_ready = ($urandom_range(0, 3) != 0);
            data_a    = WIDTH'($urandom);
            data_b    = WIDTH'($urandom);
            settle();
            check("r_grant_excl", grant_a & grant_b, 0);
            check("r_ack_excl", ack_a & ack_b, 0);
            if (!grant_a) run_a = 0;
            else if (ack_a) begin
                run_a = req_b ? run_a + 1 : 0;
                check("r_data_a", out_data, data_a);
                check("r_burst_a", run_a <= MAX_BURST, 1);
            end
            if (!grant_b) run_b = 0;
            else if (ack_b) begin
                run_b = req_a ? run_b + 1 : 0;
                check("r_data_b", out_data, data_b);
                check("r_burst_b", run_b <= MAX_BURST, 1);
            end
            tick();
        end
        quiet = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_2x1_arbiter.md
Name: mux_2x1_arbiter

Overview:
Round-robin controller that shares one 2:1-multiplexed output channel between two requesters, A and B.
- Owns the mux select and issues per-requester grants.
- Drives a valid/ready handshake toward the downstream consumer.
- Bounds each tenure to MAX_BURST transfers so that neither requester can starve the other.
- Sits between two producer blocks and a single downstream sink.

Parameters:
WIDTH, 8, data width of each requester and of the output channel
MAX_BURST, 4, maximum consecutive transfers per grant while the other side is requesting (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_a  input  1  requester A has data to send; held high while more transfers are pending
data_a  input  WIDTH  requester A payload
req_b  input  1  requester B has data to send
data_b  input  WIDTH  requester B payload
out_ready  input  1  downstream accepts out_data this cycle
grant_a  output  1  A owns the channel (registered)
grant_b  output  1  B owns the channel (registered)
sel  output  1  mux select: 0 = A, 1 = B (registered)
out_valid  output  1  out_data is valid (combinational)
out_data  output  WIDTH  sel ? data_b : data_a (combinational)
ack_a  output  1  one A word transferred this cycle (combinational)
ack_b  output  1  one B word transferred this cycle (combinational)

Behaviour:
- Sync reset:
  - state = IDLE, grant_a = grant_b = 0, sel = 0, burst count = 0.
  - Last-served pointer = B, so A wins the first tie.
  - Combinational outputs then read out_valid = 0, ack_a = ack_b = 0, out_data = data_a.
- States: IDLE, GNT_A, GNT_B. grant_a = (state == GNT_A), grant_b = (state == GNT_B). sel = 1 only in GNT_B; sel holds its last value in IDLE.
- Output handshake:
  - out_valid = (GNT_A & req_a) | (GNT_B & req_b).
  - Transfer occurs when out_valid & out_ready.
  - ack_x = transfer while in GNT_x.
  - Data is never presented without a grant.
- IDLE transitions:
  - Only req_a -> GNT_A next cycle.
  - Only req_b -> GNT_B.
  - Both -> the side that is not the last-served pointer.
  - Neither -> stay IDLE.
  - Arbitration latency: 1 cycle from req to grant.
- Pointer: updated to x on every entry into GNT_x.
- Burst count:
  - Increments on each transfer, width ceil(log2(MAX_BURST + 1)).
  - Cleared on every state change and on reaching MAX_BURST.
- GNT_x transitions, in priority order:
  1. req_x low -> IDLE, with one dead cycle before re-arbitration.
  2. Transfer makes count reach MAX_BURST and the other side is requesting -> switch directly to GNT_other, count 0.
  3. Transfer makes count reach MAX_BURST and the other side is idle -> stay in GNT_x, count 0.
  4. Otherwise stay.
- out_ready low: no transfer, count frozen, grant held indefinitely. No timeout.
- Simultaneous events:
  - req_x drops in the same cycle the count would reach MAX_BURST: no transfer occurs (out_valid = 0), so rule 1 applies.
  - The other side raising req during a burst does not preempt before MAX_BURST.
- Reset asserted mid-burst: the next cycle is IDLE with the pointer at B, regardless of the previous state. Any in-flight word is dropped, and the requester must re-present it.
- Invariants: grant_a & grant_b never both high; ack_a & ack_b never both high.

Test Plan:
1. Reset with req_a = req_b = 1 held, then release reset -> cycle 1 GNT_A, sel = 0, grant_a = 1. With out_ready = 1, exactly 4 ack_a pulses, then GNT_B next cycle with sel = 1. After 4 ack_b pulses, back to GNT_A.
2. Only req_b = 1, data_b = 8'hA5, out_ready = 1 for 10 cycles -> grant_b stays high throughout, out_data = 8'hA5, ack_b every cycle, no IDLE gaps across MAX_BURST wrap.
3. GNT_A with req_b = 1 and out_ready = 0 for 20 cycles -> grant_a held, out_valid = 1, ack_a = 0, no switch. Then raise out_ready -> 4 transfers, then switch to B.
4. Sequence of req_a high for 2 transfers then low -> IDLE for 1 cycle. With req_b low, the next req_a -> GNT_A again (pointer A, no contention).
5. Pulse reset in the middle of GNT_B after 2 transfers, with both requesting -> next cycle IDLE, sel = 0, all grants 0. Then GNT_A (pointer reset to B).
6. Random req/out_ready stimulus over 1000 cycles -> grants never overlap, at most MAX_BURST consecutive acks to one side while the other requests, and every ack_x coincides with out_data = data_x.
